// File: rtl/led_shift_sequencer_if.sv
// Board-side bundle for the LED shift sequencer: KEY/SW inputs toward the
// sequencer and shift strobes/status back toward the shift register datapath.
interface led_shift_sequencer_if;
    logic btn_left;
    logic btn_right;
    logic sin_left;
    logic sin_right;
    logic run_sw;
    logic dir_sw;
    logic shift_left;
    logic shift_right;
    logic shift_bit;
    logic running;
    logic auto_dir;

    modport master (
        output btn_left, btn_right, sin_left, sin_right, run_sw, dir_sw,
        input  shift_left, shift_right, shift_bit, running, auto_dir
    );

    modport slave (
        input  btn_left, btn_right, sin_left, sin_right, run_sw, dir_sw,
        output shift_left, shift_right, shift_bit, running, auto_dir
    );
endinterface

// File: rtl/led_shift_sequencer.sv
// Shift command sequencer: button edges and an auto-step timer arbitrated into
// one-cycle shift strobes. Define LED_SEQ_BOUNCE_EN for ping-pong auto direction.
module led_shift_sequencer #(
    parameter int WIDTH    = 8,
    parameter int TICK_DIV = 25_000_000,
    parameter int TICK_W   = 25
) (
    input  logic                  clk,
    input  logic                  reset,
    led_shift_sequencer_if.slave  bus
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state;
    logic              l_r, l_rr, r_r, r_rr;
    logic              l_req, r_req;
    logic [TICK_W-1:0] tick_cnt;
    logic              pend;

    logic tick, auto_req, auto_fire, run_exit, dir_now, dir_nxt;

`ifdef LED_SEQ_BOUNCE_EN
    localparam int STEP_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    logic [STEP_W-1:0] step_cnt;
    logic              rev, rev_nxt;
`endif

    always_comb begin
        tick      = (state == RUN) && bus.run_sw && (tick_cnt == TICK_W'(TICK_DIV - 1));
        auto_req  = (state == RUN) && bus.run_sw && (tick || pend);
        auto_fire = auto_req && !l_req && !r_req;
        run_exit  = (state == RUN) && !bus.run_sw;
`ifdef LED_SEQ_BOUNCE_EN
        rev_nxt = rev;
        if (run_exit)
            rev_nxt = 1'b0;
        else if (auto_fire && step_cnt == STEP_W'(WIDTH - 2))
            rev_nxt = ~rev;
        dir_now = bus.dir_sw ^ rev;
        dir_nxt = bus.dir_sw ^ rev_nxt;
`else
        dir_now = bus.dir_sw;
        dir_nxt = bus.dir_sw;
`endif
    end

    // Edge flags are registered once more so a press reaches the strobe with a
    // fixed two-cycle latency from the first sampling flop.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state           <= IDLE;
            l_r             <= 1'b0;
            l_rr            <= 1'b0;
            r_r             <= 1'b0;
            r_rr            <= 1'b0;
            l_req           <= 1'b0;
            r_req           <= 1'b0;
            tick_cnt        <= '0;
            pend            <= 1'b0;
            bus.shift_left  <= 1'b0;
            bus.shift_right <= 1'b0;
            bus.shift_bit   <= 1'b0;
            bus.running     <= 1'b0;
            bus.auto_dir    <= 1'b0;
        end else begin
            l_r   <= bus.btn_left;
            l_rr  <= l_r;
            r_r   <= bus.btn_right;
            r_rr  <= r_r;
            l_req <= l_r & ~l_rr;
            r_req <= r_r & ~r_rr;

            bus.shift_left  <= 1'b0;
            bus.shift_right <= 1'b0;
            bus.shift_bit   <= 1'b0;
            bus.auto_dir    <= dir_nxt;

            case (state)
                IDLE: begin
                    if (bus.run_sw) begin
                        state       <= RUN;
                        bus.running <= 1'b1;
                        tick_cnt    <= '0;
                    end
                end
                RUN: begin
                    if (!bus.run_sw) begin
                        state       <= IDLE;
                        bus.running <= 1'b0;
                        tick_cnt    <= '0;
                        pend        <= 1'b0;
                    end else begin
                        tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            // A blocked auto request parks in pend; later ticks merge into it.
            if (l_req) begin
                bus.shift_left <= 1'b1;
                bus.shift_bit  <= bus.sin_left;
                if (auto_req) pend <= 1'b1;
            end else if (r_req) begin
                bus.shift_right <= 1'b1;
                bus.shift_bit   <= bus.sin_right;
                if (auto_req) pend <= 1'b1;
            end else if (auto_req) begin
                bus.shift_left  <= ~dir_now;
                bus.shift_right <= dir_now;
                bus.shift_bit   <= dir_now ? bus.sin_right : bus.sin_left;
                pend            <= 1'b0;
            end
        end
    end

`ifdef LED_SEQ_BOUNCE_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            step_cnt <= '0;
            rev      <= 1'b0;
        end else begin
            rev <= rev_nxt;
            if (run_exit)
                step_cnt <= '0;
            else if (auto_fire)
                step_cnt <= (step_cnt == STEP_W'(WIDTH - 2)) ? '0 : step_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_led_shift_sequencer.sv
// Randomized/directed bench for led_shift_sequencer against an event-scheduling
// reference model (TICK_DIV=4, WIDTH=8).
module tb_led_shift_sequencer;
    localparam int WIDTH    = 8;
    localparam int TICK_DIV = 4;
    localparam int TICK_W   = 3;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    led_shift_sequencer_if bus ();

    led_shift_sequencer #(.WIDTH(WIDTH), .TICK_DIV(TICK_DIV), .TICK_W(TICK_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: button rises become scheduled strobes two edges later.
    int       cyc = 0;
    logic     prev_l = 1'b0, prev_r = 1'b0;
    logic [7:0] sch_l = '0, sch_r = '0;
    bit       in_run = 0, pending = 0;
    int       run_n = 0, auto_steps = 0;
    logic     e_l = 1'b0, e_r = 1'b0, e_b = 1'b0, e_run = 1'b0, e_dir = 1'b0;
    int       cnt_l = 0, cnt_r = 0;

    function automatic logic rev_of(int steps);
`ifdef LED_SEQ_BOUNCE_EN
        return logic'((steps / (WIDTH - 1)) % 2);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_edge();
        logic ml, mr, areq, d;
        if (!reset) begin
            sch_l = '0; sch_r = '0; prev_l = 1'b0; prev_r = 1'b0;
            in_run = 0; pending = 0; run_n = 0; auto_steps = 0;
            e_l = 1'b0; e_r = 1'b0; e_b = 1'b0; e_run = 1'b0; e_dir = 1'b0;
        end else begin
            ml = sch_l[cyc % 8]; sch_l[cyc % 8] = 1'b0;
            mr = sch_r[cyc % 8]; sch_r[cyc % 8] = 1'b0;
            if (bus.btn_left && !prev_l)  sch_l[(cyc + 2) % 8] = 1'b1;
            if (bus.btn_right && !prev_r) sch_r[(cyc + 2) % 8] = 1'b1;
            prev_l = bus.btn_left;
            prev_r = bus.btn_right;

            areq = 1'b0;
            if (!in_run) begin
                if (bus.run_sw) begin in_run = 1; run_n = 0; end
            end else if (!bus.run_sw) begin
                in_run = 0; pending = 0; auto_steps = 0;
            end else begin
                run_n++;
                areq = (run_n % TICK_DIV == 0) || pending;
            end

            e_l = 1'b0; e_r = 1'b0; e_b = 1'b0;
            if (ml) begin
                e_l = 1'b1; e_b = bus.sin_left;
                if (areq) pending = 1;
            end else if (mr) begin
                e_r = 1'b1; e_b = bus.sin_right;
                if (areq) pending = 1;
            end else if (areq) begin
                d = bus.dir_sw ^ rev_of(auto_steps);
                e_l = ~d; e_r = d;
                e_b = d ? bus.sin_right : bus.sin_left;
                pending = 0;
                auto_steps++;
            end
            e_run = in_run;
            e_dir = bus.dir_sw ^ rev_of(auto_steps);
        end
        cyc++;
    endtask

    task automatic check(string tag, logic obs, logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d: observed %b expected %b", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_int(string tag, int obs, int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("shift_left",  bus.shift_left,  e_l);
        check("shift_right", bus.shift_right, e_r);
        check("shift_bit",   bus.shift_bit,   e_b);
        check("running",     bus.running,     e_run);
        check("auto_dir",    bus.auto_dir,    e_dir);
        if (bus.shift_left)  cnt_l++;
        if (bus.shift_right) cnt_r++;
    endtask

    initial begin
        bus.btn_left = 0; bus.btn_right = 0; bus.sin_left = 0; bus.sin_right = 0;
        bus.run_sw = 0; bus.dir_sw = 0;
        repeat (3) step();
        reset = 1'b1;
        repeat (2) step();

        // Single held left press -> one pulse with the fill bit.
        bus.sin_left = 1; bus.btn_left = 1; cnt_l = 0; cnt_r = 0;
        repeat (12) step();
        check_int("held_left_pulses", cnt_l, 1);
        bus.btn_left = 0;
        repeat (3) step();

        // Auto right stepping, then stop.
        bus.run_sw = 1; bus.dir_sw = 1; bus.sin_right = 0;
        repeat (20) step();
        bus.run_sw = 0; cnt_r = 0;
        repeat (10) step();
        check_int("no_pulse_after_stop", cnt_r, 0);

        // Both buttons land on the auto tick; then reset aborts the pending step
        // while the buttons stay held through release.
        bus.run_sw = 1; step();
        step();
        bus.btn_left = 1; bus.btn_right = 1;
        repeat (5) step();
        bus.btn_left = 0; bus.btn_right = 0;
        repeat (4) step();
        bus.btn_left = 1; bus.btn_right = 1;
        step(); step();
        reset = 1'b0; bus.run_sw = 0;
        step();
        reset = 1'b1;
        repeat (6) step();
        bus.btn_left = 0; bus.btn_right = 0;
        repeat (3) step();

        // Fourteen auto steps from a left start.
        bus.dir_sw = 0; bus.run_sw = 1;
        step();
        cnt_l = 0; cnt_r = 0;
        repeat (14 * TICK_DIV) step();
`ifdef LED_SEQ_BOUNCE_EN
        check_int("bounce_left", cnt_l, 7);
        check_int("bounce_right", cnt_r, 7);
`else
        check_int("auto_left", cnt_l, 14);
        check_int("auto_right", cnt_r, 0);
`endif
        bus.run_sw = 0;
        repeat (3) step();

        // Random traffic with occasional resets and mode changes.
        for (int i = 0; i < 700; i++) begin
            if ($urandom_range(5) == 0) bus.btn_left  = ~bus.btn_left;
            if ($urandom_range(5) == 0) bus.btn_right = ~bus.btn_right;
            bus.sin_left  = 1'($urandom_range(1));
            bus.sin_right = 1'($urandom_range(1));
            if ($urandom_range(39) == 0) bus.run_sw = ~bus.run_sw;
            if ($urandom_range(29) == 0) bus.dir_sw = ~bus.dir_sw;
            reset = ($urandom_range(99) == 0) ? 1'b0 : 1'b1;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
